eeprom_ctrl: RTL

EEPROM_CTRL -- requirements
Module: eeprom_ctrl

---
 rtl/eeprom_pkg.sv | 30 +++
 rtl/eeprom_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/eeprom_pkg.sv
// Shared definitions for the I2C EEPROM byte-write / random-read controller:
// FSM state encoding, i2c_master byte counts and the issue-to-run state mapping.
package eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ISSUE,
        WR_RUN,
        TWR,
        RA_ISSUE,
        RA_RUN,
        RD_ISSUE,
        RD_RUN,
        RESP
    } state_t;

    localparam logic [7:0] NBYTES_ONE = 8'd1;
    localparam logic [7:0] NBYTES_TWO = 8'd2;

    // Every *_ISSUE state hands over to its matching *_RUN state once start is sent
    function automatic state_t run_of(input state_t s);
        case (s)
            WR_ISSUE: return WR_RUN;
            RA_ISSUE: return RA_RUN;
            RD_ISSUE: return RD_RUN;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_ctrl.sv
// EEPROM controller: turns host byte-write / random-read commands into i2c_master
// transactions, waits out the internal write cycle and guards each transfer with a watchdog.
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter logic [15:0] TWR_CYCLES     = 16'd5000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       m_start,
    output logic [7:0] m_nbytes,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_write_data,
    input  logic       m_tx_data_req,
    input  logic [7:0] m_read_data,
    input  logic       m_ready
);

    // TWR_CYCLES of 0 and 1 both collapse to a single wait cycle
    localparam logic [15:0] TWR_LOAD = (TWR_CYCLES == 16'd0) ? 16'd0 : TWR_CYCLES - 16'd1;

    state_t      r_state;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_m_start;
    logic        r_m_rw;
    logic [7:0]  r_m_nbytes;
    logic        r_rsp_valid;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic        r_ptr;
    logic        r_tx_req_d;
    logic        r_accepted;
    logic [15:0] r_twr_cnt;
    logic [15:0] r_wd_cnt;

    logic w_tx_fall;
    logic w_run_done;
    logic w_timeout;

    assign w_tx_fall  = r_tx_req_d & ~m_tx_data_req;
    assign w_run_done = r_accepted & m_ready;
    assign w_timeout  = ({1'b0, r_wd_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

    assign cmd_ready    = (r_state == IDLE);
    assign busy         = ~cmd_ready;
    assign m_start      = r_m_start;
    assign m_nbytes     = r_m_nbytes;
    assign m_addr       = DEV_ADDR;
    assign m_rw         = r_m_rw;
    assign m_write_data = r_ptr ? r_wdata : r_addr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_m_start   <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_nbytes  <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 8'd0;
            r_ptr       <= 1'b0;
            r_tx_req_d  <= 1'b0;
            r_accepted  <= 1'b0;
            r_twr_cnt   <= 16'd0;
            r_wd_cnt    <= 16'd0;
        end else begin
            r_m_start   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_tx_req_d  <= m_tx_data_req;
            if (w_tx_fall && !r_ptr) begin
                r_ptr <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_err   <= 1'b0;
                        r_state <= cmd_write ? WR_ISSUE : RA_ISSUE;
                    end
                end

                WR_ISSUE, RA_ISSUE, RD_ISSUE: begin
                    r_ptr      <= 1'b0;
                    r_wd_cnt   <= 16'd0;
                    r_accepted <= 1'b0;
                    r_m_rw     <= (r_state == RD_ISSUE);
                    r_m_nbytes <= (r_state == WR_ISSUE) ? NBYTES_TWO : NBYTES_ONE;
                    // Start is raised one cycle, then dropped as we move on to RUN
                    if (r_m_start) begin
                        r_state <= run_of(r_state);
                    end else if (m_ready) begin
                        r_m_start <= 1'b1;
                    end
                end

                WR_RUN, RA_RUN, RD_RUN: begin
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                    if (!m_ready) begin
                        r_accepted <= 1'b1;
                    end
                    if (w_run_done) begin
                        case (r_state)
                            WR_RUN: begin
                                r_twr_cnt <= TWR_LOAD;
                                r_state   <= TWR;
                            end
                            RA_RUN: r_state <= RD_ISSUE;
                            default: begin
                                r_rdata     <= m_read_data;
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                TWR: begin
                    if (r_twr_cnt == 16'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_twr_cnt <= r_twr_cnt - 16'd1;
                    end
                end

                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
